// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types for the intersection controller blocks.
//   state_t  : normal-mode sequencer state (IDLE=0, CLEAR=1, GREEN=2)
//   dir_t    : direction index, 2 bits (0..3)
//   NUM_DIRS : number of served directions
package traffic_pkg;
  localparam int NUM_DIRS = 4;

  typedef logic [1:0] dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    GREEN = 2'd2
  } state_t;
endpackage

// File: rtl/norm_op_unit_if.sv
// norm_op_unit_if: bundle between the intersection controller and the
// normal-mode phase sequencer.
//   norm_op_en, norm_counter_en : controller -> sequencer enables
//   allow_0_norm..allow_3_norm  : sequencer -> controller green grants
//   cur_dir                     : last direction selected for green
//   phase_done                  : pulse in the final cycle of a green phase
//   state_dbg, cnt_dbg          : observation of the sequencer FSM and timer
//
// Signalling: there is no valid/ready transfer on this bundle. Both enables
// are level-sensitive and sampled on every rising clk edge; the grants and
// debug signals are continuous views of registered state, and phase_done is
// a same-cycle combinational pulse.
interface norm_op_unit_if #(
  parameter int CNT_W = 8
);
  import traffic_pkg::*;

  logic             norm_op_en;
  logic             norm_counter_en;
  logic             allow_0_norm;
  logic             allow_1_norm;
  logic             allow_2_norm;
  logic             allow_3_norm;
  dir_t             cur_dir;
  logic             phase_done;
  state_t           state_dbg;
  logic [CNT_W-1:0] cnt_dbg;

  // Controller side.
  modport master (
    output norm_op_en, norm_counter_en,
    input  allow_0_norm, allow_1_norm, allow_2_norm, allow_3_norm,
    input  cur_dir, phase_done, state_dbg, cnt_dbg
  );

  // Sequencer side.
  modport slave (
    input  norm_op_en, norm_counter_en,
    output allow_0_norm, allow_1_norm, allow_2_norm, allow_3_norm,
    output cur_dir, phase_done, state_dbg, cnt_dbg
  );
endinterface

// File: rtl/phase_timer.sv
// phase_timer: CNT_W-bit phase counter.
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear to zero (wins over en)
//   en       : count enable
//   term     : terminal value for the current phase
//   cnt      : current count
//   at_term  : cnt equals term
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             at_term
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  assign at_term = (cnt == term);

  // Counting stops at term so the counter can never wrap even if the
  // owner forgets to clear it on expiry.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !at_term) begin
      cnt <= cnt + ONE;
    end
  end
endmodule

// File: rtl/norm_op_unit.sv
// norm_op_unit: normal-mode phase sequencer. Serves directions 0->1->2->3
// round-robin, each green of GREEN_CYCLES counted cycles preceded by an
// all-stop clearance of CLEAR_CYCLES counted cycles.
//   clk, rst : clock and synchronous active-high reset
//   bus      : norm_op_unit_if slave (enables in; grants, cur_dir,
//              phase_done and state/counter observation out)
module norm_op_unit
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES = 20,
  parameter int CLEAR_CYCLES = 3,
  parameter int CNT_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  norm_op_unit_if.slave   bus
);
  localparam logic [CNT_W-1:0] GREEN_TERM = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_TERM = CNT_W'(CLEAR_CYCLES - 1);

  state_t           state;
  dir_t             dir;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;
  logic             at_term;
  logic             expire;
  logic             tmr_clr;

  assign term   = (state == GREEN) ? GREEN_TERM : CLEAR_TERM;
  assign expire = bus.norm_counter_en && at_term;

  // The counter restarts from zero on every phase boundary: while idle,
  // on any disable, and on expiry of the running phase.
  assign tmr_clr = (state == IDLE) || !bus.norm_op_en || expire;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (bus.norm_counter_en),
    .term    (term),
    .cnt     (cnt),
    .at_term (at_term)
  );

  // dir is advanced on CLEAR->GREEN, so a green interrupted by a disable
  // is not re-served on resume: the next green goes to dir+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dir   <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (bus.norm_op_en) state <= CLEAR;
        end
        CLEAR: begin
          if (!bus.norm_op_en) begin
            state <= IDLE;
          end else if (expire) begin
            state <= GREEN;
            dir   <= dir + 2'd1;
          end
        end
        GREEN: begin
          if (!bus.norm_op_en) state <= IDLE;
          else if (expire)     state <= CLEAR;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.allow_0_norm = (state == GREEN) && (dir == 2'd0);
  assign bus.allow_1_norm = (state == GREEN) && (dir == 2'd1);
  assign bus.allow_2_norm = (state == GREEN) && (dir == 2'd2);
  assign bus.allow_3_norm = (state == GREEN) && (dir == 2'd3);
  assign bus.phase_done   = (state == GREEN) && bus.norm_op_en && expire;
  assign bus.cur_dir      = dir;
  assign bus.state_dbg    = state;
  assign bus.cnt_dbg      = cnt;
endmodule

// File: tb/tb_norm_op_unit.sv
// tb_norm_op_unit: randomized and directed stimulus for norm_op_unit with a
// timeline-based reference model and a per-cycle expected-value queue.
module tb_norm_op_unit;
  import traffic_pkg::*;

  localparam int G = 4;
  localparam int C = 2;
  localparam int P = C + G;
  localparam int W = 8;
  localparam int EW = 2 + 2 + 1 + 4 + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  norm_op_unit_if #(.CNT_W(W)) bus ();

  norm_op_unit #(
    .GREEN_CYCLES (G),
    .CLEAR_CYCLES (C),
    .CNT_W        (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  // Within an enabled session the behaviour is a fixed timeline of counted
  // ticks: each period of P ticks is C clear ticks followed by G green ticks.
  bit m_active;
  int m_ticks;
  int m_base;

  function automatic int m_pos();
    return m_ticks % P;
  endfunction

  function automatic int m_dir();
    return (m_base + (m_ticks + G) / P) % NUM_DIRS;
  endfunction

  function automatic bit m_green();
    return m_active && (m_pos() >= C);
  endfunction

  function automatic logic [EW-1:0] expect_word(input bit en, input bit cen);
    logic [1:0]   st;
    logic [1:0]   d;
    logic         pd;
    logic [3:0]   al;
    logic [W-1:0] c;
    int           di;
    int           ci;
    di = m_active ? m_dir() : m_base;
    d  = di[1:0];
    if (!m_active)     st = 2'd0;
    else if (m_green()) st = 2'd2;
    else               st = 2'd1;
    pd = m_green() && en && cen && (m_pos() == P - 1);
    al = m_green() ? (4'b0001 << d) : 4'b0000;
    if (!m_active)       ci = 0;
    else if (m_pos() < C) ci = m_pos();
    else                 ci = m_pos() - C;
    c = ci[W-1:0];
    return {st, d, pd, al, c};
  endfunction

  task automatic model_step(input bit en, input bit cen, input bit r);
    if (r) begin
      m_active = 1'b0;
      m_base   = 3;
      m_ticks  = 0;
    end else if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_ticks  = 0;
      end
    end else if (!en) begin
      m_base   = m_dir();
      m_active = 1'b0;
    end else if (cen) begin
      m_ticks++;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int clear_run = 0;
  bit prev_green = 1'b0;

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; expected value for the
  // cycle is queued before the monitor samples on the falling edge.
  task automatic drive_cycle(input bit en, input bit cen, input bit r);
    bus.norm_op_en      = en;
    bus.norm_counter_en = cen;
    rst                 = r;
    exp_q.push_back(expect_word(en, cen));
    @(posedge clk);
    model_step(en, cen, r);
    #1;
  endtask

  task automatic run_enabled(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 1'b0);
  endtask

  // Run with both enables high until the model reaches timeline position
  // want_pos (and direction want_dir unless it is negative).
  task automatic advance_to(input int want_dir, input int want_pos, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_active && m_pos() == want_pos && (want_dir < 0 || m_dir() == want_dir))
        found = 1'b1;
      else
        drive_cycle(1'b1, 1'b1, 1'b0);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL advance_%s: target dir=%0d pos=%0d not reached within 200 cycles", tag, want_dir, want_pos);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] exp_w;
    logic [EW-1:0] act_w;
    logic [3:0]    al;
    bit            g;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      al    = {bus.allow_3_norm, bus.allow_2_norm, bus.allow_1_norm, bus.allow_0_norm};
      act_w = {bus.state_dbg, bus.cur_dir, bus.phase_done, al, bus.cnt_dbg};
      total++;
      if (act_w !== exp_w) begin
        bad++;
        $display("FAIL outputs cyc=%0d: got state=%0d dir=%0d done=%0b allow=%b cnt=%0d, want state=%0d dir=%0d done=%0b allow=%b cnt=%0d",
                 cyc, act_w[EW-1:EW-2], act_w[EW-3:EW-4], act_w[EW-5], act_w[EW-6:EW-9], act_w[W-1:0],
                 exp_w[EW-1:EW-2], exp_w[EW-3:EW-4], exp_w[EW-5], exp_w[EW-6:EW-9], exp_w[W-1:0]);
      end
      total++;
      if ($countones(al) > 1) begin
        bad++;
        $display("FAIL one_hot cyc=%0d: got allow=%b, want at most one bit set", cyc, al);
      end
      g = (bus.state_dbg == GREEN);
      if (g && !prev_green) begin
        total++;
        if (clear_run < C) begin
          bad++;
          $display("FAIL clear_before_green cyc=%0d: got %0d counted clear cycles, want >= %0d", cyc, clear_run, C);
        end
      end
      if (bus.state_dbg == CLEAR) begin
        if (bus.norm_op_en && bus.norm_counter_en) clear_run++;
      end else begin
        clear_run = 0;
      end
      prev_green = g;
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst                 = 1'b1;
    bus.norm_op_en      = 1'b0;
    bus.norm_counter_en = 1'b0;
    @(posedge clk);
    model_step(1'b0, 1'b0, 1'b1);
    #1;

    // Reset state, with enables high during reset.
    drive_cycle(1'b1, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b1);

    // Full rotation plus wrap back to direction 0.
    run_enabled(5 * P);

    // Count-enable stall in the second cycle of dir-1 green.
    advance_to(1, C + 1, "dir1_green");
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0);
    run_enabled(10);

    // Disable in the second cycle of dir-2 green, resume 5 cycles later.
    advance_to(2, C + 1, "dir2_green");
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    run_enabled(2 * P);

    // Disable in the cycle the clearance expires.
    advance_to(-1, C - 1, "clear_expiry");
    drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    run_enabled(2 * P);

    // Reset in the middle of a green with enables held high.
    advance_to(-1, C + 2, "mid_green");
    drive_cycle(1'b1, 1'b1, 1'b1);
    run_enabled(2 * P);

    // Randomized enables and occasional reset.
    for (int i = 0; i < 600; i++) begin
      drive_cycle($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
    end
    run_enabled(P);

    // Let the monitor consume the last expected entry.
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
